// File: rtl/sound_pkg.sv
// Shared definitions for the rc_mixer_n sound mixer.
//   SAMPLE_W / RAMP_W : sample width and gate ramp counter width
//   gate_st_e         : per-channel gate states
//   top_st_e          : mixer sequencing states
//   sat16()           : clamp a sign-extended 64-bit value to a 16-bit sample
package sound_pkg;
  localparam int SAMPLE_W = 16;
  localparam int RAMP_W   = 8;

  typedef enum logic [1:0] {G_MUTED, G_UNMUTING, G_OPEN, G_MUTING} gate_st_e;
  typedef enum logic [1:0] {T_IDLE, T_ACC, T_UPD} top_st_e;

  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [63:0] v);
    if (v > 64'sd32767)       return 16'sh7fff;
    else if (v < -64'sd32768) return 16'sh8000;
    else                      return v[SAMPLE_W-1:0];
  endfunction
endpackage

// File: rtl/rc_mixer_gate.sv
// Per-channel mute gate with 256-step exponential ramp.
//   clk, rst : clock, async active-high reset
//   mute     : level mute request, edge-detected every cycle
//   adv      : accepted-sample strobe; ramp counter advances only on it
//   sin      : channel sample
//   g        : gated sample (combinational from current gate state)
module rc_mixer_gate
  import sound_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       mute,
  input  logic                       adv,
  input  logic signed [SAMPLE_W-1:0] sin,
  output logic signed [SAMPLE_W-1:0] g
);
  gate_st_e            st_q, st_d;
  logic [RAMP_W-1:0]   cnt_q, cnt_d;
  logic                mute_q, mute_d;
  logic                rise, fall;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    mute_d = mute;
    rise   = mute & ~mute_q;
    fall   = ~mute & mute_q;
    // A mute edge wins over a ramp step landing in the same cycle.
    if (rise && (st_q == G_OPEN || st_q == G_UNMUTING)) begin
      st_d  = G_MUTING;
      cnt_d = '0;
    end else if (fall && (st_q == G_MUTED || st_q == G_MUTING)) begin
      st_d  = G_UNMUTING;
      cnt_d = '0;
    end else if (adv && (st_q == G_MUTING || st_q == G_UNMUTING)) begin
      if (cnt_q == '1) begin
        if (st_q == G_MUTING) st_d = G_MUTED;
        else                  st_d = G_OPEN;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Top two counter bits pick the attenuation quarter (0..3 bit shifts).
  always_comb begin
    g = '0;
    case (st_q)
      G_OPEN:     g = sin;
      G_MUTING:   g = sin >>> cnt_q[RAMP_W-1 -: 2];
      G_UNMUTING: g = sin >>> ~cnt_q[RAMP_W-1 -: 2];
      default:    g = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= G_MUTED;
      cnt_q  <= '0;
      mute_q <= 1'b1;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mute_q <= mute_d;
    end
  end
endmodule

// File: rtl/rc_mixer_n.sv
// N-channel gated mixer followed by a first-order RC (Euler) low-pass.
//   clk, rst  : clock, async active-high reset
//   sample_en : one-cycle sample strobe, accepted only when idle
//   sound_in  : NUM_CH signed 16-bit samples, channel i at [16*i +: 16]
//   weight    : per-channel shift weight 0..3, channel i at [2*i +: 2]
//   mute      : per-channel mute request
//   sound_out : saturated filtered mix; out_valid pulses when it updates
//   overrun   : sticky, set by a strobe that arrives while busy
// Optional: define RC_MIXER_N_DC_BLOCK_EN to add a one-pole DC blocker
// after saturation (one extra cycle of latency).
module rc_mixer_n
  import sound_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int DELTA_SHIFT = 7,
  parameter int OUT_SHIFT   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sample_en,
  input  logic [SAMPLE_W*NUM_CH-1:0] sound_in,
  input  logic [2*NUM_CH-1:0]        weight,
  input  logic [NUM_CH-1:0]          mute,
  output logic signed [SAMPLE_W-1:0] sound_out,
  output logic                       out_valid,
  output logic                       overrun
);
  // Sized so the worst-case sum of weighted differences never wraps.
  localparam int AW = SAMPLE_W + 4 + $clog2(NUM_CH) + 1;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int SW = AW + OUT_SHIFT;

  logic                                accept;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     g_w;

  top_st_e                             fsm_q, fsm_d;
  logic [CW-1:0]                       ch_q, ch_d;
  logic signed [AW-1:0]                acc_q, acc_d, st_q, st_d;
  // Latched gate outputs already carry the latched sound_in values.
  logic [NUM_CH-1:0][SAMPLE_W-1:0]     g_q, g_d;
  logic [NUM_CH-1:0][1:0]              w_q, w_d;
  logic signed [SAMPLE_W-1:0]          out_q, out_d;
  logic                                vld_q, vld_d, ovr_q, ovr_d;

  logic signed [SAMPLE_W-1:0]          g_sel;
  logic signed [AW-1:0]                term;
  logic signed [SW-1:0]                st_sh;
  logic signed [SAMPLE_W-1:0]          sat_x;

  assign accept = sample_en && (fsm_q == T_IDLE);

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_gate
    rc_mixer_gate u_gate (
      .clk  (clk),
      .rst  (rst),
      .mute (mute[gi]),
      .adv  (accept),
      .sin  (sound_in[SAMPLE_W*gi +: SAMPLE_W]),
      .g    (g_w[gi])
    );
  end

`ifdef RC_MIXER_N_DC_BLOCK_EN
  logic signed [SAMPLE_W-1:0] dcx_q, dcx_d, xp_q, xp_d, yp_q, yp_d, dc_y;
  logic                       dcv_q, dcv_d;
`endif

  always_comb begin
    fsm_d = fsm_q;
    ch_d  = ch_q;
    acc_d = acc_q;
    st_d  = st_q;
    g_d   = g_q;
    w_d   = w_q;
    out_d = out_q;
    vld_d = 1'b0;
    ovr_d = ovr_q | (sample_en && fsm_q != T_IDLE);
    g_sel = g_q[ch_q];
    term  = (AW'(g_sel) - st_q) <<< w_q[ch_q];
    st_sh = '0;
    sat_x = '0;
`ifdef RC_MIXER_N_DC_BLOCK_EN
    dcx_d = dcx_q;
    dcv_d = 1'b0;
    xp_d  = xp_q;
    yp_d  = yp_q;
    dc_y  = '0;
`endif
    case (fsm_q)
      T_IDLE: if (sample_en) begin
        g_d   = g_w;
        w_d   = weight;
        acc_d = '0;
        ch_d  = '0;
        fsm_d = T_ACC;
      end
      T_ACC: begin
        acc_d = acc_q + term;
        if (ch_q == CW'(NUM_CH - 1)) fsm_d = T_UPD;
        else                          ch_d  = ch_q + 1'b1;
      end
      T_UPD: begin
        st_d  = st_q + (acc_q >>> DELTA_SHIFT);
        st_sh = SW'(st_d) <<< OUT_SHIFT;
        sat_x = sat16(64'(st_sh));
`ifdef RC_MIXER_N_DC_BLOCK_EN
        dcx_d = sat_x;
        dcv_d = 1'b1;
`else
        out_d = sat_x;
        vld_d = 1'b1;
`endif
        fsm_d = T_IDLE;
      end
      default: fsm_d = T_IDLE;
    endcase
`ifdef RC_MIXER_N_DC_BLOCK_EN
    // y = x - x_prev + y_prev - y_prev/1024, clamped back to a sample.
    if (dcv_q) begin
      dc_y  = sat16(64'(dcx_q) - 64'(xp_q) + 64'(yp_q) - 64'(yp_q >>> 10));
      out_d = dc_y;
      vld_d = 1'b1;
      xp_d  = dcx_q;
      yp_d  = dc_y;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q <= T_IDLE;
      ch_q  <= '0;
      acc_q <= '0;
      st_q  <= '0;
      g_q   <= '0;
      w_q   <= '0;
      out_q <= '0;
      vld_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      fsm_q <= fsm_d;
      ch_q  <= ch_d;
      acc_q <= acc_d;
      st_q  <= st_d;
      g_q   <= g_d;
      w_q   <= w_d;
      out_q <= out_d;
      vld_q <= vld_d;
      ovr_q <= ovr_d;
    end
  end

`ifdef RC_MIXER_N_DC_BLOCK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dcx_q <= '0;
      dcv_q <= 1'b0;
      xp_q  <= '0;
      yp_q  <= '0;
    end else begin
      dcx_q <= dcx_d;
      dcv_q <= dcv_d;
      xp_q  <= xp_d;
      yp_q  <= yp_d;
    end
  end
`endif

  assign sound_out = out_q;
  assign out_valid = vld_q;
  assign overrun   = ovr_q;
endmodule

// File: doc/rc_mixer_n.md
RC_MIXER_N -- requirements
Module: rc_mixer_n

Interface
REQ-001 SHALL have parameter NUM_CH, default 3, number of input channels (legal 1..8).
REQ-002 SHALL have parameter DELTA_SHIFT, default 7, Euler step right-shift.
REQ-003 SHALL have parameter OUT_SHIFT, default 2, output left-shift before saturation.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port sample_en  in  1  one-cycle sample strobe.
REQ-007 SHALL have port sound_in  in  16*NUM_CH  signed samples; channel i at bits [16*i+15:16*i].
REQ-008 SHALL have port weight  in  2*NUM_CH  per-channel shift weight 0..3; channel i at bits [2*i+1:2*i].
REQ-009 SHALL have port mute  in  NUM_CH  per-channel mute request, level-sensitive.
REQ-010 SHALL have port sound_out  out  16  signed filtered mix.
REQ-011 SHALL have port out_valid  out  1  one-cycle pulse when sound_out updates.
REQ-012 SHALL have port overrun  out  1  sticky flag, set when sample_en arrives while busy.

Function
REQ-013 Each channel SHALL have a gate FSM with states MUTED, UNMUTING, OPEN, MUTING and an 8-bit ramp counter.
REQ-014 Gate transitions: mute 0->1 from OPEN/UNMUTING -> MUTING; mute 1->0 from MUTED/MUTING -> UNMUTING; each transition clears the ramp counter.
REQ-015 Ramp counter SHALL increment once per accepted sample in MUTING/UNMUTING; at 255 the gate SHALL enter MUTED (from MUTING) or OPEN (from UNMUTING).
REQ-016 Gated sample g_i SHALL be: OPEN sound_in; MUTED 0; MUTING sound_in >>> cnt[7:6]; UNMUTING sound_in >>> ~cnt[7:6]; arithmetic shift.
REQ-017 Top FSM states: IDLE, ACC, UPD; sample_en in IDLE SHALL latch sound_in, weight and gate outputs, clear acc, and enter ACC with ch=0.
REQ-018 In ACC, one channel per cycle: acc += (g_ch - state) <<< weight_ch; after ch=NUM_CH-1 go to UPD.
REQ-019 In UPD: state += acc >>> DELTA_SHIFT; sound_out <= saturate(state <<< OUT_SHIFT) to [-32768, 32767]; out_valid=1; return to IDLE.
REQ-020 Latency: sample_en at cycle t -> out_valid and new sound_out at cycle t+NUM_CH+2.
REQ-021 acc and state SHALL be signed, width 16+4+clog2(NUM_CH)+1; no intermediate wrap permitted.
REQ-022 sample_en outside IDLE SHALL be ignored (no latch, no gate advance) and SHALL set overrun.
REQ-023 Mute edges SHALL be detected every cycle; gate advance SHALL occur only on accepted samples.

Reset
REQ-024 rst SHALL force: top FSM IDLE, acc=0, state=0, sound_out=0, out_valid=0, overrun=0, all gates MUTED, ramp counters 0, mute history = 1.
REQ-025 rst asserted mid-ACC SHALL abort the computation; no out_valid is produced for that sample.

Configuration
REQ-026 With RC_MIXER_N_DC_BLOCK_EN defined, UPD SHALL apply y = x - x_prev + y_prev - (y_prev >>> 10) to the saturated value before sound_out, adding one cycle of latency (t+NUM_CH+3); x_prev, y_prev reset to 0.
REQ-027 Without RC_MIXER_N_DC_BLOCK_EN, no DC-block logic SHALL exist and latency is per REQ-020.

Structure
REQ-028 Package sound_pkg SHALL hold SAMPLE_W=16, RAMP_W=8, the gate state enum and the top FSM state enum.
REQ-029 Per-channel gate SHALL be sub-module rc_mixer_gate, instantiated NUM_CH times by generate.

Verification
REQ-030 NUM_CH=3, all mute=0 for 256+ samples, ch0=10000, weights 0 -> sound_out converges toward saturate(10000*4/3 scaled)=monotonic rise, no overshoot, never exceeds 32767.
REQ-031 sample_en at t, NUM_CH=3 -> out_valid exactly at t+5 (t+6 with DC block); second sample_en at t+2 -> ignored, overrun=1 until rst.
REQ-032 ch1=8000 OPEN, mute 0->1 -> g_1 = 8000, 4000, 2000, 1000 across 64-sample quarters, then 0 after 256 samples.
REQ-033 mute toggled 1->0 at ramp count 100 of MUTING -> UNMUTING with counter 0, g starts at sound_in>>>3.
REQ-034 All inputs +32767, weight 3, OUT_SHIFT 2 -> sound_out clamps at 32767; all -32768 -> clamps at -32768.
REQ-035 rst pulse during ACC -> sound_out=0, out_valid stays 0, next sample computes from state=0.
